// File: rtl/muldiv_pkg.sv
// Shared types and constants for the RV32M multiply/divide unit.
//   md_op_e    : RV32M funct3 encodings
//   md_state_e : unit FSM states
//   MD_DIV0_QUOT / MD_OVF_QUOT : fixed quotients for divide-by-zero and signed overflow
package muldiv_pkg;

    typedef enum logic [2:0] {
        MD_MUL    = 3'b000,
        MD_MULH   = 3'b001,
        MD_MULHSU = 3'b010,
        MD_MULHU  = 3'b011,
        MD_DIV    = 3'b100,
        MD_DIVU   = 3'b101,
        MD_REM    = 3'b110,
        MD_REMU   = 3'b111
    } md_op_e;

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        DONE
    } md_state_e;

    localparam logic [31:0] MD_DIV0_QUOT = '1;
    localparam logic [31:0] MD_OVF_QUOT  = 32'h8000_0000;

endpackage

// File: rtl/muldiv_div_core.sv
// Restoring shift-subtract divider datapath operating on unsigned magnitudes.
// Ports:
//   clk, reset          : clock, synchronous active-high reset
//   start               : load dividend/divisor and arm the datapath
//   dividend, divisor   : operand magnitudes, sampled when start=1
//   last                : the step taken this cycle is the final one; stop afterwards
//   quotient, remainder : values after the step taken this cycle (combinational), so the
//                         caller can register the final answer on the edge of the last step
module muldiv_div_core
    import muldiv_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic [DATA_WIDTH-1:0] dividend,
    input  logic [DATA_WIDTH-1:0] divisor,
    output logic [DATA_WIDTH-1:0] quotient,
    output logic [DATA_WIDTH-1:0] remainder,
    input  logic                  last
);

    localparam int unsigned W = DATA_WIDTH;

    logic [W-1:0] quo_q, quo_d;
    logic [W-1:0] rem_q, rem_d;
    logic [W-1:0] dvs_q, dvs_d;
    logic         run_q, run_d;
    logic [W:0]   rem_sh;
    logic [W:0]   diff;

    always_comb begin
        quo_d  = quo_q;
        rem_d  = rem_q;
        dvs_d  = dvs_q;
        run_d  = run_q;
        // Partial remainder is always below the divisor, so W+1 bits cover the shifted value
        rem_sh = {rem_q, quo_q[W-1]};
        diff   = rem_sh - {1'b0, dvs_q};
        if (start) begin
            quo_d = dividend;
            rem_d = '0;
            dvs_d = divisor;
            run_d = 1'b1;
        end else if (run_q) begin
            if (!diff[W]) begin
                rem_d = diff[W-1:0];
                quo_d = {quo_q[W-2:0], 1'b1};
            end else begin
                rem_d = rem_sh[W-1:0];
                quo_d = {quo_q[W-2:0], 1'b0};
            end
            if (last) begin
                run_d = 1'b0;
            end
        end
        quotient  = quo_d;
        remainder = rem_d;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            quo_q <= '0;
            rem_q <= '0;
            dvs_q <= '0;
            run_q <= 1'b0;
        end else begin
            quo_q <= quo_d;
            rem_q <= rem_d;
            dvs_q <= dvs_d;
            run_q <= run_d;
        end
    end

endmodule

// File: rtl/riscv_muldiv.sv
// Iterative RV32M multiply/divide unit (MUL/MULH/MULHSU/MULHU/DIV/DIVU/REM/REMU).
// Ports:
//   clk, reset            : clock, synchronous active-high reset
//   req_valid, req_ready  : request handshake; req_ready is high only in IDLE
//   funct3, SrcA, SrcB    : operation and operands, sampled only at the accept edge
//   resp_valid, resp_ready: response handshake; MDResult held while resp_valid=1
//   MDResult              : 32-bit result
// Build option MULDIV_FAST_MUL_EN: multiplies use a combinational 33x33 signed multiplier
// and complete one edge after accept; otherwise they iterate one shift-add step per cycle.
module riscv_muldiv
    import muldiv_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned CNT_WIDTH  = 6
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic [2:0]            funct3,
    input  logic [DATA_WIDTH-1:0] SrcA,
    input  logic [DATA_WIDTH-1:0] SrcB,
    output logic                  resp_valid,
    input  logic                  resp_ready,
    output logic [DATA_WIDTH-1:0] MDResult
);

    localparam int unsigned W = DATA_WIDTH;

    md_state_e            state_q, state_d;
    logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
    md_op_e               op_q, op_d;
    logic                 neg_q, neg_d;
    logic [W-1:0]         result_q, result_d;

    logic         is_div_in, a_signed_in, b_signed_in, a_neg_in, b_neg_in, neg_in;
    logic [W-1:0] a_mag, b_mag;
    logic         special_in;
    logic [W-1:0] special_res;
    logic         div_start, busy_last;
    logic [W-1:0] div_quo, div_rem, div_final, mul_final;

`ifdef MULDIV_FAST_MUL_EN
    logic signed [2*W+1:0] fast_prod;
    logic [1:0]            unused_fast_hi;
`endif

    // Accept-side decode: signedness, magnitudes, result sign and the no-iteration cases
    always_comb begin
        is_div_in   = funct3[2];
        a_signed_in = is_div_in ? ~funct3[0] : (funct3[1:0] != 2'b11);
        b_signed_in = is_div_in ? ~funct3[0] : ~funct3[1];
        a_neg_in    = a_signed_in & SrcA[W-1];
        b_neg_in    = b_signed_in & SrcB[W-1];
        a_mag       = a_neg_in ? -SrcA : SrcA;
        b_mag       = b_neg_in ? -SrcB : SrcB;
        // Remainder takes the dividend's sign; everything else the product of signs
        neg_in      = (is_div_in && funct3[1]) ? a_neg_in : (a_neg_in ^ b_neg_in);
        special_in  = 1'b0;
        special_res = '0;
        if (is_div_in && (SrcB == '0)) begin
            special_in  = 1'b1;
            special_res = funct3[1] ? SrcA : MD_DIV0_QUOT;
        end else if (is_div_in && !funct3[0] && (SrcA == MD_OVF_QUOT) && (SrcB == '1)) begin
            special_in  = 1'b1;
            special_res = funct3[1] ? '0 : MD_OVF_QUOT;
        end
`ifdef MULDIV_FAST_MUL_EN
        if (!is_div_in) begin
            special_in  = 1'b1;
            special_res = (funct3 == 3'b000) ? fast_prod[W-1:0] : fast_prod[2*W-1:W];
        end
`endif
    end

`ifdef MULDIV_FAST_MUL_EN
    assign fast_prod = $signed({a_signed_in & SrcA[W-1], SrcA}) *
                       $signed({b_signed_in & SrcB[W-1], SrcB});
    assign unused_fast_hi = fast_prod[2*W+1:2*W];
    assign mul_final      = '0;
`else
    logic [2*W-1:0] prod_q, prod_d, prod_fix;
    logic [W-1:0]   mcand_q, mcand_d;
    logic [W:0]     acc;

    // Shift-add on magnitudes: multiplier sits in the low half and shifts out LSB first
    always_comb begin
        prod_d  = prod_q;
        mcand_d = mcand_q;
        acc     = '0;
        if (div_start) begin
            prod_d  = {{W{1'b0}}, b_mag};
            mcand_d = a_mag;
        end else if (state_q == BUSY) begin
            acc    = {1'b0, prod_q[2*W-1:W]} + (prod_q[0] ? {1'b0, mcand_q} : '0);
            prod_d = {acc, prod_q[W-1:1]};
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            prod_q  <= '0;
            mcand_q <= '0;
        end else begin
            prod_q  <= prod_d;
            mcand_q <= mcand_d;
        end
    end

    assign prod_fix  = neg_q ? -prod_d : prod_d;
    assign mul_final = (op_q == MD_MUL) ? prod_fix[W-1:0] : prod_fix[2*W-1:W];
`endif

    assign busy_last = (state_q == BUSY) && (cnt_q == CNT_WIDTH'(W - 1));

    muldiv_div_core #(
        .DATA_WIDTH(W)
    ) u_div_core (
        .clk      (clk),
        .reset    (reset),
        .start    (div_start),
        .dividend (a_mag),
        .divisor  (b_mag),
        .quotient (div_quo),
        .remainder(div_rem),
        .last     (busy_last)
    );

    always_comb begin
        if (op_q[1]) begin
            div_final = neg_q ? -div_rem : div_rem;
        end else begin
            div_final = neg_q ? -div_quo : div_quo;
        end
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        op_d      = op_q;
        neg_d     = neg_q;
        result_d  = result_q;
        div_start = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (req_valid) begin
                    op_d  = md_op_e'(funct3);
                    neg_d = neg_in;
                    cnt_d = '0;
                    if (special_in) begin
                        result_d = special_res;
                        state_d  = DONE;
                    end else begin
                        div_start = 1'b1;
                        state_d   = BUSY;
                    end
                end
            end
            BUSY: begin
                cnt_d = cnt_q + 1'b1;
                if (busy_last) begin
                    result_d = op_q[2] ? div_final : mul_final;
                    state_d  = DONE;
                end
            end
            DONE: begin
                if (resp_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            op_q     <= MD_MUL;
            neg_q    <= 1'b0;
            result_q <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            op_q     <= op_d;
            neg_q    <= neg_d;
            result_q <= result_d;
        end
    end

    assign req_ready  = (state_q == IDLE);
    assign resp_valid = (state_q == DONE);
    assign MDResult   = result_q;

endmodule

// File: tb/tb_riscv_muldiv.sv
// Directed self-checking bench for riscv_muldiv.
module tb_riscv_muldiv;

`ifdef MULDIV_FAST_MUL_EN
    localparam int MUL_LAT = 1;
`else
    localparam int MUL_LAT = 33;
`endif
    localparam int DIV_LAT = 33;

    logic        clk;
    logic        reset;
    logic        req_valid;
    logic        req_ready;
    logic [2:0]  funct3;
    logic [31:0] SrcA;
    logic [31:0] SrcB;
    logic        resp_valid;
    logic        resp_ready;
    logic [31:0] MDResult;

    int          n_checks;
    int          n_fail;
    logic [31:0] res;
    int          lat;

    riscv_muldiv u_dut (
        .clk       (clk),
        .reset     (reset),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .funct3    (funct3),
        .SrcA      (SrcA),
        .SrcB      (SrcB),
        .resp_valid(resp_valid),
        .resp_ready(resp_ready),
        .MDResult  (MDResult)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Issue one op, scramble inputs after accept, wait for the response and consume it.
    // lat = 1 means resp_valid is already up in the cycle right after the accept edge.
    task automatic run_op(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                          output logic [31:0] r, output int l);
        int n;
        @(negedge clk);
        funct3    = f3;
        SrcA      = a;
        SrcB      = b;
        req_valid = 1'b1;
        n = 0;
        while (!req_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        funct3    = ~f3;
        SrcA      = 32'hDEAD_BEEF;
        SrcB      = 32'h0;
        l = 1;
        while (!resp_valid && l < 100) begin
            @(negedge clk);
            l++;
        end
        r          = MDResult;
        resp_ready = 1'b1;
        @(negedge clk);
        resp_ready = 1'b0;
    endtask

    task automatic run_check(input string tag, input logic [2:0] f3, input logic [31:0] a,
                             input logic [31:0] b, input logic [31:0] exp, input int exp_lat);
        logic [31:0] r;
        int          l;
        run_op(f3, a, b, r, l);
        check(tag, r, exp);
        check({tag, "_lat"}, l, exp_lat);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        n_checks   = 0;
        n_fail     = 0;
        reset      = 1'b1;
        req_valid  = 1'b0;
        resp_ready = 1'b0;
        funct3     = 3'b000;
        SrcA       = '0;
        SrcB       = '0;
        repeat (3) @(negedge clk);
        check("rst_req_ready", req_ready, 1);
        check("rst_resp_valid", resp_valid, 0);
        check("rst_result", MDResult, 0);
        reset = 1'b0;

        // Multiply
        run_check("mul_7x-3", 3'b000, 32'd7, 32'hFFFF_FFFD, 32'hFFFF_FFEB, MUL_LAT);
        run_check("mulhu_ff", 3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, MUL_LAT);
        run_check("mulh_ff", 3'b001, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000, MUL_LAT);
        run_check("mulhsu_ff", 3'b010, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, MUL_LAT);
        run_check("mulh_min", 3'b001, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, MUL_LAT);
        run_check("mul_ff", 3'b000, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0001, MUL_LAT);

        // Divide
        run_check("div_-7_2", 3'b100, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, DIV_LAT);
        run_check("rem_-7_2", 3'b110, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, DIV_LAT);
        run_check("div_7_-2", 3'b100, 32'd7, 32'hFFFF_FFFE, 32'hFFFF_FFFD, DIV_LAT);
        run_check("rem_7_-2", 3'b110, 32'd7, 32'hFFFF_FFFE, 32'h0000_0001, DIV_LAT);
        run_check("divu_100_7", 3'b101, 32'd100, 32'd7, 32'd14, DIV_LAT);
        run_check("remu_100_7", 3'b111, 32'd100, 32'd7, 32'd2, DIV_LAT);
        run_check("divu_big", 3'b101, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0, DIV_LAT);

        // No-iteration cases
        run_check("divu_5_0", 3'b101, 32'd5, 32'd0, 32'hFFFF_FFFF, 1);
        run_check("rem_5_0", 3'b110, 32'd5, 32'd0, 32'd5, 1);
        run_check("div_ovf", 3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1);
        run_check("rem_ovf", 3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0, 1);

        // Backpressure and request held while busy
        @(negedge clk);
        funct3    = 3'b101;
        SrcA      = 32'd100;
        SrcB      = 32'd7;
        req_valid = 1'b1;
        check("bp_idle_ready", req_ready, 1);
        @(posedge clk);
        @(negedge clk);
        funct3 = 3'b111;
        repeat (5) @(negedge clk);
        check("bp_busy_ready", req_ready, 0);
        lat = 0;
        while (!resp_valid && lat < 100) begin
            @(negedge clk);
            lat++;
        end
        check("bp_resp_seen", resp_valid, 1);
        for (int i = 0; i < 10; i++) begin
            check("bp_hold_valid", resp_valid, 1);
            check("bp_hold_result", MDResult, 32'd14);
            check("bp_hold_ready", req_ready, 0);
            @(negedge clk);
        end
        resp_ready = 1'b1;
        @(negedge clk);
        resp_ready = 1'b0;
        check("bp_second_ready", req_ready, 1);
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        lat = 1;
        while (!resp_valid && lat < 100) begin
            @(negedge clk);
            lat++;
        end
        check("bp_second_result", MDResult, 32'd2);
        check("bp_second_lat", lat, DIV_LAT);
        resp_ready = 1'b1;
        @(negedge clk);
        resp_ready = 1'b0;

        // Reset while BUSY with counter at 12
        @(negedge clk);
        funct3    = 3'b101;
        SrcA      = 32'd1000;
        SrcB      = 32'd10;
        req_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        repeat (12) @(posedge clk);
        @(negedge clk);
        check("mid_busy", req_ready, 0);
        reset = 1'b1;
        @(negedge clk);
        check("mid_rst_ready", req_ready, 1);
        check("mid_rst_valid", resp_valid, 0);
        check("mid_rst_result", MDResult, 0);
        reset = 1'b0;
        run_check("post_rst_divu", 3'b101, 32'd9, 32'd3, 32'd3, DIV_LAT);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
